// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the instruction sequencer.
//   - opcode constants and instruction field positions (16-bit format)
//   - sel_alu codes driven to the datapath ALU
//   - sequencer FSM state enum and decoded instruction class enum
package cpu_pkg;

   localparam int INSTR_W = 16;

   // field positions: [15:12] opcode, [11:8] rd, [7:0] imm/target, [3:0] rs
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;
   localparam int RS_HI  = 3;
   localparam int RS_LO  = 0;

   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_LDI  = 4'h1;
   localparam logic [3:0] OPC_MOV  = 4'h2;
   localparam logic [3:0] OPC_ADD  = 4'h3;
   localparam logic [3:0] OPC_SUB  = 4'h4;
   localparam logic [3:0] OPC_AND  = 4'h5;
   localparam logic [3:0] OPC_OR   = 4'h6;
   localparam logic [3:0] OPC_XOR  = 4'h7;
   localparam logic [3:0] OPC_JMP  = 4'h8;
   localparam logic [3:0] OPC_JZ   = 4'h9;
   localparam logic [3:0] OPC_HALT = 4'hF;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;
   localparam logic [2:0] ALU_XOR  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_OP2    = 3'd3,
      ST_OP1    = 3'd4,
      ST_EXEC   = 3'd5,
      ST_WRITE  = 3'd6,
      ST_HALT   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CL_NOP  = 3'd0,
      CL_LDI  = 3'd1,
      CL_MOV  = 3'd2,
      CL_ALU  = 3'd3,
      CL_JMP  = 3'd4,
      CL_JZ   = 3'd5,
      CL_HALT = 3'd6
   } iclass_e;

   function automatic logic [3:0] fld_opcode(input logic [INSTR_W-1:0] i);
      return i[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode decoder.
//   opcode    in  4 : instruction opcode field
//   iclass    out   : instruction class (NOP/LDI/MOV/ALU/JMP/JZ/HALT)
//   alu_op    out 3 : sel_alu code for EXEC (PASS for LDI/MOV/non-ALU)
//   uses_rs   out 1 : instruction reads rs from the register file
//   is_branch out 1 : JMP or JZ
// Opcodes 0xA-0xE fall through as NOP.
module ctrl_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output iclass_e    iclass,
   output logic [2:0] alu_op,
   output logic       uses_rs,
   output logic       is_branch
);

   always_comb begin
      iclass    = CL_NOP;
      alu_op    = ALU_PASS;
      uses_rs   = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OPC_LDI: iclass = CL_LDI;
         OPC_MOV: begin
            iclass  = CL_MOV;
            uses_rs = 1'b1;
         end
         OPC_ADD: begin
            iclass  = CL_ALU;
            alu_op  = ALU_ADD;
            uses_rs = 1'b1;
         end
         OPC_SUB: begin
            iclass  = CL_ALU;
            alu_op  = ALU_SUB;
            uses_rs = 1'b1;
         end
         OPC_AND: begin
            iclass  = CL_ALU;
            alu_op  = ALU_AND;
            uses_rs = 1'b1;
         end
         OPC_OR: begin
            iclass  = CL_ALU;
            alu_op  = ALU_OR;
            uses_rs = 1'b1;
         end
         OPC_XOR: begin
            iclass  = CL_ALU;
            alu_op  = ALU_XOR;
            uses_rs = 1'b1;
         end
         OPC_JMP: begin
            iclass    = CL_JMP;
            is_branch = 1'b1;
         end
         OPC_JZ: begin
            iclass    = CL_JZ;
            is_branch = 1'b1;
         end
         OPC_HALT: iclass = CL_HALT;
         default: iclass = CL_NOP;
      endcase
   end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: instruction sequencer driving the datapath control inputs.
//   clk       in        : clock, all state changes on rising edge
//   rst       in        : synchronous reset, active-low
//   run       in        : start execution, sampled in IDLE only
//   instr     in  IW    : program ROM data, valid one cycle after pc
//   alu_zero  in        : datapath zero flag, sampled in WRITE
//   pc        out PC_W  : program ROM address
//   r_wf, en_rf, en_reg, en_alu, en_imm, imm, sel_alu, sel_rf, sel_mux
//             out       : datapath controls (Moore, from state and IR)
//   halted    out       : HALT executed; left only through reset
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | pc presented to ROM
// DECODE | ROM data valid; IR loaded, next state / branch chosen
// OP2    | ALU: rs read into op2 register; LDI: immediate loaded
// OP1    | op1 selected (rd for ALU, rs for MOV, immediate for LDI)
// EXEC   | ALU enabled with the instruction's operation
// WRITE  | result written to rd, Z captured, pc+1
// HALT   | stopped, pc frozen, all enables low
module ctrl_unit
   import cpu_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int IW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [IW-1:0]   instr,
   input  logic            alu_zero,
   output logic [PC_W-1:0] pc,
   output logic            r_wf,
   output logic            en_rf,
   output logic            en_reg,
   output logic            en_alu,
   output logic            en_imm,
   output logic [7:0]      imm,
   output logic [2:0]      sel_alu,
   output logic [3:0]      sel_rf,
   output logic            sel_mux,
   output logic            halted
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            z_q, z_d;

   // IR is held pre-decoded: the opcode is stored as its decoded class and
   // ALU code, the operand bits [11:0] are kept verbatim.
   logic [11:0]     ir_q, ir_d;
   iclass_e         cls_q, cls_d;
   logic [2:0]      alu_q, alu_d;
   logic            uses_rs_q, uses_rs_d;

   iclass_e         dec_class;
   logic [2:0]      dec_alu;
   logic            dec_uses_rs;
   logic            dec_branch;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_tgt;
   logic [3:0]      ir_rd;
   logic [3:0]      ir_rs;

   // Decoder only looks at live ROM data; it is consulted in DECODE alone,
   // so no output ever depends combinationally on instr.
   ctrl_decode u_decode (
      .opcode    (fld_opcode(instr)),
      .iclass    (dec_class),
      .alu_op    (dec_alu),
      .uses_rs   (dec_uses_rs),
      .is_branch (dec_branch)
   );

   assign pc_inc = pc_q + PC_W'(1);
   assign pc_tgt = PC_W'(instr[IMM_HI:IMM_LO]);
   assign ir_rd  = ir_q[RD_HI:RD_LO];
   assign ir_rs  = ir_q[RS_HI:RS_LO];
   assign pc     = pc_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         z_q       <= 1'b0;
         ir_q      <= '0;
         cls_q     <= CL_NOP;
         alu_q     <= ALU_PASS;
         uses_rs_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         z_q       <= z_d;
         ir_q      <= ir_d;
         cls_q     <= cls_d;
         alu_q     <= alu_d;
         uses_rs_q <= uses_rs_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      z_d       = z_q;
      ir_d      = ir_q;
      cls_d     = cls_q;
      alu_d     = alu_q;
      uses_rs_d = uses_rs_q;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            ir_d      = instr[11:0];
            cls_d     = dec_class;
            alu_d     = dec_alu;
            uses_rs_d = dec_uses_rs;
            if (dec_branch) begin
               state_d = ST_FETCH;
               pc_d    = (dec_class == CL_JMP || z_q) ? pc_tgt : pc_inc;
            end else begin
               case (dec_class)
                  CL_ALU, CL_LDI: state_d = ST_OP2;
                  CL_MOV:         state_d = ST_OP1;
                  CL_HALT:        state_d = ST_HALT;
                  default: begin
                     state_d = ST_FETCH;
                     pc_d    = pc_inc;
                  end
               endcase
            end
         end
         ST_OP2:  state_d = ST_OP1;
         ST_OP1:  state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WRITE;
         ST_WRITE: begin
            z_d     = alu_zero;
            pc_d    = pc_inc;
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      r_wf    = 1'b0;
      en_rf   = 1'b0;
      en_reg  = 1'b0;
      en_alu  = 1'b0;
      en_imm  = 1'b0;
      sel_alu = ALU_PASS;
      sel_rf  = 4'd0;
      sel_mux = 1'b0;
      halted  = 1'b0;
      imm     = ir_q[IMM_HI:IMM_LO];
      case (state_q)
         ST_OP2: begin
            if (uses_rs_q) begin
               en_rf  = 1'b1;
               sel_rf = ir_rs;
               en_reg = 1'b1;
            end else if (cls_q == CL_LDI) begin
               en_imm = 1'b1;
            end
         end
         ST_OP1, ST_EXEC: begin
            // EXEC keeps the OP1 operand selection so op1 stays stable
            // while the ALU consumes it.
            case (cls_q)
               CL_LDI: sel_mux = 1'b1;
               CL_MOV: begin
                  sel_rf = ir_rs;
                  en_rf  = (state_q == ST_OP1);
               end
               CL_ALU: begin
                  sel_rf = ir_rd;
                  en_rf  = (state_q == ST_OP1);
               end
               default: sel_mux = 1'b0;
            endcase
            if (state_q == ST_EXEC) begin
               en_alu  = 1'b1;
               sel_alu = alu_q;
            end
         end
         ST_WRITE: begin
            en_rf  = 1'b1;
            r_wf   = 1'b1;
            sel_rf = ir_rd;
         end
         ST_HALT: halted = 1'b1;
         default: halted = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ctrl_unit.sv
module tb_ctrl_unit;

   typedef struct packed {
      logic [7:0] pc;
      logic       halted;
      logic       r_wf;
      logic       en_rf;
      logic       en_reg;
      logic       en_alu;
      logic       en_imm;
      logic [7:0] imm;
      logic [2:0] sel_alu;
      logic [3:0] sel_rf;
      logic       sel_mux;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic        alu_zero = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic [7:0]  pc;
   logic        r_wf, en_rf, en_reg, en_alu, en_imm, sel_mux, halted;
   logic [7:0]  imm;
   logic [2:0]  sel_alu;
   logic [3:0]  sel_rf;

   int n_chk = 0;
   int n_bad = 0;

   logic [15:0] rom [256];

   bit          az_mode = 1'b0;
   logic        az_val  = 1'b0;

   // reference model state (instruction level)
   obs_t        exp_q[$];
   logic [7:0]  m_pc   = 8'h00;
   logic [15:0] m_ir   = 16'h0000;
   logic        m_z    = 1'b0;
   bit          m_idle = 1'b1;
   bit          m_halt = 1'b0;
   bit          m_live = 1'b0;

   ctrl_unit #(.PC_W(8), .IW(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .instr    (instr),
      .alu_zero (alu_zero),
      .pc       (pc),
      .r_wf     (r_wf),
      .en_rf    (en_rf),
      .en_reg   (en_reg),
      .en_alu   (en_alu),
      .en_imm   (en_imm),
      .imm      (imm),
      .sel_alu  (sel_alu),
      .sel_rf   (sel_rf),
      .sel_mux  (sel_mux),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   // synchronous ROM: data for pc appears one cycle later
   always @(posedge clk) instr <= rom[pc];

   initial begin
      forever begin
         @(posedge clk);
         #1;
         alu_zero = az_mode ? az_val : 1'($urandom_range(0, 1));
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic obs_t base(input logic [7:0] p, input logic [15:0] irv);
      obs_t o;
      o     = '0;
      o.pc  = p;
      o.imm = irv[7:0];
      return o;
   endfunction

   // Push the expected per-cycle outputs of the instruction at m_pc,
   // starting with its FETCH cycle, and advance the architectural model.
   task automatic plan_instr();
      obs_t        f, o, w;
      logic [15:0] n;
      logic [3:0]  op, rd, rs;
      if (m_halt) begin
         o        = base(m_pc, m_ir);
         o.halted = 1'b1;
         exp_q.push_back(o);
         return;
      end
      n  = rom[m_pc];
      op = n[15:12];
      rd = n[11:8];
      rs = n[3:0];
      f  = base(m_pc, m_ir);
      exp_q.push_back(f);
      exp_q.push_back(f);
      m_ir = n;
      o = base(m_pc, m_ir);
      w = o;
      w.en_rf = 1'b1; w.r_wf = 1'b1; w.sel_rf = rd;
      if (op >= 4'h3 && op <= 4'h7) begin
         f = o; f.en_rf = 1'b1; f.sel_rf = rs; f.en_reg = 1'b1; exp_q.push_back(f);
         f = o; f.en_rf = 1'b1; f.sel_rf = rd; exp_q.push_back(f);
         f = o; f.en_alu = 1'b1; f.sel_alu = 3'(op - 4'h2); f.sel_rf = rd; exp_q.push_back(f);
         exp_q.push_back(w);
         m_pc = 8'(m_pc + 8'd1);
      end else if (op == 4'h1) begin
         f = o; f.en_imm = 1'b1; exp_q.push_back(f);
         f = o; f.sel_mux = 1'b1; exp_q.push_back(f);
         f = o; f.sel_mux = 1'b1; f.en_alu = 1'b1; exp_q.push_back(f);
         exp_q.push_back(w);
         m_pc = 8'(m_pc + 8'd1);
      end else if (op == 4'h2) begin
         f = o; f.en_rf = 1'b1; f.sel_rf = rs; exp_q.push_back(f);
         f = o; f.en_alu = 1'b1; f.sel_rf = rs; exp_q.push_back(f);
         exp_q.push_back(w);
         m_pc = 8'(m_pc + 8'd1);
      end else if (op == 4'h8) begin
         m_pc = n[7:0];
      end else if (op == 4'h9) begin
         m_pc = m_z ? n[7:0] : 8'(m_pc + 8'd1);
      end else if (op == 4'hF) begin
         m_halt = 1'b1;
      end else begin
         m_pc = 8'(m_pc + 8'd1);
      end
   endtask

   // lock-step comparison of every cycle against the model
   always @(negedge clk) begin
      obs_t a, e;
      if (m_live) begin
         a.pc = pc; a.halted = halted; a.r_wf = r_wf; a.en_rf = en_rf;
         a.en_reg = en_reg; a.en_alu = en_alu; a.en_imm = en_imm; a.imm = imm;
         a.sel_alu = sel_alu; a.sel_rf = sel_rf; a.sel_mux = sel_mux;
         if (m_idle) begin
            e = base(m_pc, m_ir);
            if (run) m_idle = 1'b0;
         end else begin
            if (exp_q.size() == 0) plan_instr();
            e = exp_q.pop_front();
            if (e.r_wf) m_z = alu_zero;
         end
         chk_eq("cycle", 32'(a), 32'(e));
      end
      if (!rst) begin
         exp_q.delete();
         m_pc   = 8'h00;
         m_ir   = 16'h0000;
         m_z    = 1'b0;
         m_idle = 1'b1;
         m_halt = 1'b0;
         m_live = 1'b1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst = 1'b0;
      run = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      cyc(2);
   endtask

   // leaves the bench one cycle into the first FETCH
   task automatic release_start();
      rst = 1'b1;
      cyc(1);
      run = 1'b1;
      cyc(1);
      run = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

      // reset held with run high
      rst = 1'b0;
      run = 1'b1;
      cyc(3);
      chk_eq("rst_pc", 32'(pc), 32'h0);
      chk_eq("rst_halted", 32'(halted), 32'h0);
      chk_eq("rst_ctrl", 32'({r_wf, en_rf, en_reg, en_alu, en_imm, imm, sel_alu, sel_rf, sel_mux}), 32'h0);
      rst = 1'b1;
      run = 1'b0;
      cyc(4);
      chk_eq("idle_pc", 32'(pc), 32'h0);
      chk_eq("idle_en_rf", 32'(en_rf), 32'h0);

      // LDI r1,5 ; LDI r2,3 ; ADD r1,r2
      hold_reset();
      rom[0] = 16'h1105; rom[1] = 16'h1203; rom[2] = 16'h3102; rom[3] = 16'hF000;
      release_start();
      cyc(5);
      chk_eq("ldi1_wr_sel_rf", 32'(sel_rf), 32'd1);
      chk_eq("ldi1_wr_imm", 32'(imm), 32'h05);
      chk_eq("ldi1_wr_r_wf", 32'(r_wf), 32'd1);
      cyc(6);
      chk_eq("ldi2_wr_sel_rf", 32'(sel_rf), 32'd2);
      chk_eq("ldi2_wr_imm", 32'(imm), 32'h03);
      cyc(3);
      chk_eq("add_op2_sel_rf", 32'(sel_rf), 32'd2);
      chk_eq("add_op2_en_reg", 32'(en_reg), 32'd1);
      cyc(2);
      chk_eq("add_exec_sel_alu", 32'(sel_alu), 32'd1);
      cyc(1);
      chk_eq("add_wr_sel_rf", 32'(sel_rf), 32'd1);
      chk_eq("add_wr_r_wf", 32'(r_wf), 32'd1);
      cyc(1);
      chk_eq("pc_after_18", 32'(pc), 32'd3);

      // SUB r1,r1 with zero result, then JZ taken / not taken
      for (int k = 0; k < 2; k++) begin
         hold_reset();
         rom[0] = 16'h4101; rom[1] = 16'h9010; rom[2] = 16'hF000; rom[16] = 16'hF000;
         az_mode = 1'b1;
         az_val  = (k == 0);
         release_start();
         cyc(8);
         chk_eq(k == 0 ? "jz_taken_pc" : "jz_not_taken_pc", 32'(pc), k == 0 ? 32'h10 : 32'h02);
         az_mode = 1'b0;
      end

      // NOP at 0xFF wraps to 0
      hold_reset();
      rom[0] = 16'h80FF; rom[255] = 16'h0000;
      release_start();
      cyc(2);
      chk_eq("jmp_ff_pc", 32'(pc), 32'hFF);
      cyc(2);
      chk_eq("nop_wrap_pc", 32'(pc), 32'h00);

      // opcode 0xB behaves as NOP
      hold_reset();
      rom[0] = 16'hB123; rom[1] = 16'hF000;
      release_start();
      cyc(2);
      chk_eq("opb_pc", 32'(pc), 32'd1);
      chk_eq("opb_enables", 32'({en_rf, en_reg, en_alu, en_imm, r_wf}), 32'h0);

      // HALT at pc=4, run toggling, then reset
      hold_reset();
      rom[4] = 16'hF000;
      release_start();
      cyc(10);
      chk_eq("halt_flag", 32'(halted), 32'd1);
      for (int i = 0; i < 20; i++) begin
         run = ~run;
         cyc(1);
      end
      run = 1'b0;
      chk_eq("halt_pc_frozen", 32'(pc), 32'd4);
      chk_eq("halt_still", 32'(halted), 32'd1);
      rst = 1'b0;
      cyc(1);
      chk_eq("halt_rst_flag", 32'(halted), 32'd0);
      chk_eq("halt_rst_pc", 32'(pc), 32'd0);
      rst = 1'b1;
      cyc(1);

      // reset during EXEC of ADD aborts the write
      hold_reset();
      rom[0] = 16'h3102;
      release_start();
      cyc(4);
      chk_eq("abort_exec_en_alu", 32'(en_alu), 32'd1);
      rst = 1'b0;
      cyc(1);
      chk_eq("abort_en_rf", 32'(en_rf), 32'd0);
      chk_eq("abort_r_wf", 32'(r_wf), 32'd0);
      rst = 1'b1;
      cyc(3);
      chk_eq("abort_idle_en_rf", 32'(en_rf), 32'd0);
      chk_eq("abort_idle_pc", 32'(pc), 32'd0);

      // random programs, random run and occasional reset
      for (int p = 0; p < 25; p++) begin
         hold_reset();
         for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
            rom[i] = {op, 12'($urandom_range(0, 4095))};
         end
         rst = 1'b1;
         for (int c = 0; c < 300; c++) begin
            run = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) != 0);
            cyc(1);
         end
      end

      rst = 1'b1;
      run = 1'b0;
      cyc(2);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
